// File: rtl/instr_bus_pkg.sv
// rtl/instr_bus_pkg.sv - shared types and constants for the instruction-side bus decoder
package instr_bus_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int INTG_W = 7;

   localparam logic [ADDR_W-1:0] ROM_BASE_DEF = 32'h0000_0000;
   localparam logic [ADDR_W-1:0] ROM_MASK_DEF = 32'hFFFF_FF00;
   localparam logic [ADDR_W-1:0] RAM_BASE_DEF = 32'h0001_0000;
   localparam logic [ADDR_W-1:0] RAM_MASK_DEF = 32'hFFFF_0000;

   typedef enum logic [1:0] {
      TGT_ROM,
      TGT_RAM,
      TGT_ERR
   } tgt_e;

endpackage

// File: rtl/instr_tgt_fifo.sv
// rtl/instr_tgt_fifo.sv - in-order FIFO of targets for outstanding fetches
module instr_tgt_fifo
   import instr_bus_pkg::*;
#(
   parameter int  DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  tgt_e             push_tgt,
   input  logic             pop,
   output tgt_e             head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   tgt_e             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_tgt;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/instr_bus_decoder.sv
// rtl/instr_bus_decoder.sv - routes core fetches to boot ROM, instruction SRAM or an error responder
module instr_bus_decoder
   import instr_bus_pkg::*;
#(
   parameter logic [ADDR_W-1:0] ROM_BASE        = ROM_BASE_DEF,
   parameter logic [ADDR_W-1:0] ROM_MASK        = ROM_MASK_DEF,
   parameter logic [ADDR_W-1:0] RAM_BASE        = RAM_BASE_DEF,
   parameter logic [ADDR_W-1:0] RAM_MASK        = RAM_MASK_DEF,
   parameter int                MAX_OUTSTANDING = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m_req_i,
   output logic              m_gnt_o,
   input  logic [ADDR_W-1:0] m_addr_i,
   output logic              m_rvalid_o,
   output logic [DATA_W-1:0] m_rdata_o,
   output logic [INTG_W-1:0] m_rdata_intg_o,
   output logic              m_err_o,
   output logic              rom_req_o,
   input  logic              rom_gnt_i,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic              rom_rvalid_i,
   input  logic [DATA_W-1:0] rom_rdata_i,
   input  logic [INTG_W-1:0] rom_rdata_intg_i,
   input  logic              rom_err_i,
   output logic              ram_req_o,
   input  logic              ram_gnt_i,
   output logic [ADDR_W-1:0] ram_addr_o,
   input  logic              ram_rvalid_i,
   input  logic [DATA_W-1:0] ram_rdata_i,
   input  logic [INTG_W-1:0] ram_rdata_intg_i,
   input  logic              ram_err_i,
   output logic              proto_err_o
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   tgt_e             tgt;
   tgt_e             head;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] err_pend;
   logic             full;
   logic             empty;
   logic             allow;
   logic             issue;
   logic             err_gnt;
   logic             err_rvalid;
   logic             rom_stray;
   logic             ram_stray;

   always_comb begin
      tgt = TGT_ERR;
      if ((m_addr_i & ROM_MASK) == ROM_BASE)      tgt = TGT_ROM;
      else if ((m_addr_i & RAM_MASK) == RAM_BASE) tgt = TGT_RAM;
   end

   // FIFO entries always share one target, so comparing the head covers them all.
   assign allow   = !full && ((count == '0) || (head == tgt));
   assign issue   = !rst && m_req_i && allow;
   assign err_gnt = issue && (tgt == TGT_ERR);

   assign rom_req_o  = issue && (tgt == TGT_ROM);
   assign ram_req_o  = issue && (tgt == TGT_RAM);
   assign rom_addr_o = m_addr_i;
   assign ram_addr_o = m_addr_i;
   assign m_gnt_o    = (rom_req_o && rom_gnt_i) || (ram_req_o && ram_gnt_i) || err_gnt;

   instr_tgt_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (m_gnt_o),
      .push_tgt (tgt),
      .pop      (m_rvalid_o),
      .head     (head),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   assign err_rvalid = (err_pend != '0) && !empty && (head == TGT_ERR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_pend <= '0;
      else     err_pend <= err_pend + CNT_W'(err_gnt) - CNT_W'(err_rvalid);
   end

   always_comb begin
      m_rvalid_o     = 1'b0;
      m_rdata_o      = '0;
      m_rdata_intg_o = '0;
      m_err_o        = 1'b0;
      if (!rst && !empty) begin
         case (head)
            TGT_ROM: if (rom_rvalid_i) begin
               m_rvalid_o     = 1'b1;
               m_rdata_o      = rom_rdata_i;
               m_rdata_intg_o = rom_rdata_intg_i;
               m_err_o        = rom_err_i;
            end
            TGT_RAM: if (ram_rvalid_i) begin
               m_rvalid_o     = 1'b1;
               m_rdata_o      = ram_rdata_i;
               m_rdata_intg_o = ram_rdata_intg_i;
               m_err_o        = ram_err_i;
            end
            default: if (err_rvalid) begin
               m_rvalid_o = 1'b1;
               m_err_o    = 1'b1;
            end
         endcase
      end
   end

   // A slave answering when it is not at the head of the queue is dropped and flagged.
   assign rom_stray = rom_rvalid_i && (empty || (head != TGT_ROM));
   assign ram_stray = ram_rvalid_i && (empty || (head != TGT_RAM));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         proto_err_o <= 1'b0;
      else if (rom_stray || ram_stray) proto_err_o <= 1'b1;
   end

endmodule

// File: tb/tb_instr_bus_decoder.sv
// tb/tb_instr_bus_decoder.sv - randomized scoreboard bench for instr_bus_decoder
module tb_instr_bus_decoder;
   import instr_bus_pkg::*;

   localparam int MAXO = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        m_req_i, m_gnt_o, m_rvalid_o, m_err_o;
   logic [31:0] m_addr_i, m_rdata_o;
   logic [6:0]  m_rdata_intg_o;
   logic        rom_req_o, rom_gnt_i, rom_rvalid_i, rom_err_i;
   logic [31:0] rom_addr_o, rom_rdata_i;
   logic [6:0]  rom_rdata_intg_i;
   logic        ram_req_o, ram_gnt_i, ram_rvalid_i, ram_err_i;
   logic [31:0] ram_addr_o, ram_rdata_i;
   logic [6:0]  ram_rdata_intg_i;
   logic        proto_err_o;

   instr_bus_decoder #(.MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .rst(rst),
      .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_addr_i(m_addr_i),
      .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o), .m_rdata_intg_o(m_rdata_intg_o), .m_err_o(m_err_o),
      .rom_req_o(rom_req_o), .rom_gnt_i(rom_gnt_i), .rom_addr_o(rom_addr_o), .rom_rvalid_i(rom_rvalid_i),
      .rom_rdata_i(rom_rdata_i), .rom_rdata_intg_i(rom_rdata_intg_i), .rom_err_i(rom_err_i),
      .ram_req_o(ram_req_o), .ram_gnt_i(ram_gnt_i), .ram_addr_o(ram_addr_o), .ram_rvalid_i(ram_rvalid_i),
      .ram_rdata_i(ram_rdata_i), .ram_rdata_intg_i(ram_rdata_intg_i), .ram_err_i(ram_err_i),
      .proto_err_o(proto_err_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Memory map in plain address ranges: 0..0xFF ROM, 0x10000..0x1FFFF RAM, rest unmapped
   function automatic int ref_tgt(input logic [31:0] a);
      if (a <= 32'h0000_00FF) return 0;
      if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF) return 1;
      return 2;
   endfunction

   function automatic logic [31:0] rom_data(input logic [31:0] a); return a * 32'd3 + 32'h0000_0513; endfunction
   function automatic logic [6:0]  rom_intg(input logic [31:0] a); return a[8:2] ^ 7'h55; endfunction
   function automatic logic        rom_err (input logic [31:0] a); return a[4] & a[3]; endfunction
   function automatic logic [31:0] ram_data(input logic [31:0] a); return ~a ^ 32'hC0DE_0000; endfunction
   function automatic logic [6:0]  ram_intg(input logic [31:0] a); return a[6:0] + 7'd9; endfunction
   function automatic logic        ram_err (input logic [31:0] a); return a[5] & a[2]; endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] bnd [5] = '{32'h0000_00FF, 32'h0000_0100, 32'h0000_FFFC, 32'h0001_FFFF, 32'h0002_0000};
      int k = $urandom_range(0, 9);
      if (k <= 3) return {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if (k <= 7) return {16'h0001, 14'($urandom), 2'b00};
      if (k == 8) return 32'h4000_0000 + 32'($urandom_range(0, 255));
      return bnd[$urandom_range(0, 4)];
   endfunction

   // ---------------- slave models ----------------
   typedef struct { logic [31:0] d; logic [6:0] i; logic e; int due; } rsp_t;
   rsp_t rom_q[$];
   rsp_t ram_q[$];
   int   lat_fixed [2] = '{0, 0};
   bit   gnt_always[2] = '{1'b0, 1'b0};
   int   inject_cyc[2] = '{-1, -1};

   initial begin : rom_slave
      rsp_t r;
      int   last = 0;
      rom_gnt_i = 0; rom_rvalid_i = 0; rom_rdata_i = 0; rom_rdata_intg_i = 0; rom_err_i = 0;
      forever begin
         @(negedge clk);
         if (!rst && rom_req_o && rom_gnt_i) begin
            r.d = rom_data(rom_addr_o); r.i = rom_intg(rom_addr_o); r.e = rom_err(rom_addr_o);
            r.due = cyc + ((lat_fixed[0] > 0) ? lat_fixed[0] : $urandom_range(1, 3));
            if (r.due <= last) r.due = last + 1;
            last = r.due;
            rom_q.push_back(r);
         end
         @(posedge clk); #1;
         rom_gnt_i = gnt_always[0] ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (inject_cyc[0] == cyc) begin
            rom_rvalid_i = 1; rom_rdata_i = 32'hDEAD_BEEF; rom_rdata_intg_i = 7'h7F; rom_err_i = 1;
         end else if (rom_q.size() > 0 && rom_q[0].due <= cyc) begin
            r = rom_q.pop_front();
            rom_rvalid_i = 1; rom_rdata_i = r.d; rom_rdata_intg_i = r.i; rom_err_i = r.e;
         end else begin
            rom_rvalid_i = 0; rom_rdata_i = $urandom; rom_rdata_intg_i = 7'($urandom); rom_err_i = 1'($urandom);
         end
      end
   end

   initial begin : ram_slave
      rsp_t r;
      int   last = 0;
      ram_gnt_i = 0; ram_rvalid_i = 0; ram_rdata_i = 0; ram_rdata_intg_i = 0; ram_err_i = 0;
      forever begin
         @(negedge clk);
         if (!rst && ram_req_o && ram_gnt_i) begin
            r.d = ram_data(ram_addr_o); r.i = ram_intg(ram_addr_o); r.e = ram_err(ram_addr_o);
            r.due = cyc + ((lat_fixed[1] > 0) ? lat_fixed[1] : $urandom_range(1, 3));
            if (r.due <= last) r.due = last + 1;
            last = r.due;
            ram_q.push_back(r);
         end
         @(posedge clk); #1;
         ram_gnt_i = gnt_always[1] ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (inject_cyc[1] == cyc) begin
            ram_rvalid_i = 1; ram_rdata_i = 32'hBAD0_0BAD; ram_rdata_intg_i = 7'h2A; ram_err_i = 1;
         end else if (ram_q.size() > 0 && ram_q[0].due <= cyc) begin
            r = ram_q.pop_front();
            ram_rvalid_i = 1; ram_rdata_i = r.d; ram_rdata_intg_i = r.i; ram_err_i = r.e;
         end else begin
            ram_rvalid_i = 0; ram_rdata_i = $urandom; ram_rdata_intg_i = 7'($urandom); ram_err_i = 1'($urandom);
         end
      end
   end

   // ---------------- scoreboard / monitor ----------------
   typedef struct { int kind; logic [31:0] d; logic [6:0] i; logic e; int gcyc; } exp_t;
   exp_t sb[$];
   logic exp_proto = 1'b0;

   always @(negedge clk) begin : monitor
      exp_t ne;
      int   tq, hk;
      logic alw, e_rom, e_ram, e_gnt, erv;
      if (rst) begin
         chk("rst_gnt", m_gnt_o, 0);
         chk("rst_rvalid", m_rvalid_o, 0);
         chk("rst_rom_req", rom_req_o, 0);
         chk("rst_ram_req", ram_req_o, 0);
         chk("rst_proto", proto_err_o, 0);
         sb.delete();
         exp_proto = 1'b0;
      end else begin
         chk("proto_err", proto_err_o, exp_proto);
         tq  = ref_tgt(m_addr_i);
         alw = (sb.size() < MAXO);
         foreach (sb[k]) if (sb[k].kind != tq) alw = 1'b0;
         e_rom = m_req_i && alw && (tq == 0);
         e_ram = m_req_i && alw && (tq == 1);
         e_gnt = (e_rom && rom_gnt_i) || (e_ram && ram_gnt_i) || (m_req_i && alw && (tq == 2));
         chk("rom_req", rom_req_o, e_rom);
         chk("ram_req", ram_req_o, e_ram);
         chk("gnt", m_gnt_o, e_gnt);
         chk("rom_addr", rom_addr_o, m_addr_i);
         chk("ram_addr", ram_addr_o, m_addr_i);
         hk  = (sb.size() > 0) ? sb[0].kind : -1;
         erv = ((hk == 0) && rom_rvalid_i) || ((hk == 1) && ram_rvalid_i) ||
               ((hk == 2) && (cyc == sb[0].gcyc + 1));
         chk("rvalid", m_rvalid_o, erv);
         if (erv) begin
            chk("rdata", m_rdata_o, sb[0].d);
            chk("rintg", m_rdata_intg_o, sb[0].i);
            chk("rerr", m_err_o, sb[0].e);
            void'(sb.pop_front());
         end else begin
            chk("idle_rdata", m_rdata_o, 0);
            chk("idle_intg", m_rdata_intg_o, 0);
            chk("idle_err", m_err_o, 0);
         end
         if (rom_rvalid_i && hk != 0) exp_proto = 1'b1;
         if (ram_rvalid_i && hk != 1) exp_proto = 1'b1;
         if (e_gnt) begin
            ne.kind = tq; ne.gcyc = cyc;
            case (tq)
               0:       begin ne.d = rom_data(m_addr_i); ne.i = rom_intg(m_addr_i); ne.e = rom_err(m_addr_i); end
               1:       begin ne.d = ram_data(m_addr_i); ne.i = ram_intg(m_addr_i); ne.e = ram_err(m_addr_i); end
               default: begin ne.d = 0; ne.i = 0; ne.e = 1'b1; end
            endcase
            sb.push_back(ne);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic fetch(input logic [31:0] a);
      int n = 0;
      m_req_i  = 1'b1;
      m_addr_i = a;
      while (1) begin
         @(negedge clk);
         if (m_gnt_o) break;
         if (++n > 100) begin
            tests++; fails++;
            $display("FAIL gnt_timeout: got no grant for %h expected grant within 100 cycles", a);
            break;
         end
      end
      @(posedge clk); #1;
      m_req_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic random_phase(input int num);
      for (int i = 0; i < num; i++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         fetch(rand_addr());
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500000 time units");
      $fatal(1);
   end

   initial begin : main
      rst = 1'b1; m_req_i = 1'b0; m_addr_i = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      m_req_i = 1'b1; m_addr_i = 32'h80;
      @(posedge clk); #1;
      rst = 1'b0; m_req_i = 1'b0;
      @(posedge clk); #1;

      fetch(32'h80);
      fetch(32'h4000_0000);
      random_phase(300);
      drain();

      // back-to-back ROM, fixed 2-cycle latency: third request must wait for the first response
      lat_fixed[0] = 2; gnt_always[0] = 1'b1;
      fetch(32'h80); fetch(32'h84); fetch(32'h88); fetch(32'h8C);
      drain();
      lat_fixed[0] = 0; gnt_always[0] = 1'b0;

      // ROM outstanding, then RAM must wait for the drain
      fetch(32'h80); fetch(32'h0001_0000);
      drain();

      inject_cyc[0] = cyc + 2;
      repeat (4) begin @(posedge clk); #1; end
      chk("proto_sticky_set", proto_err_o, 1);
      fetch(32'h80);
      drain();
      chk("proto_sticky_hold", proto_err_o, 1);

      // reset with two RAM fetches in flight; their responses arrive after release
      lat_fixed[1] = 10; gnt_always[1] = 1'b1;
      fetch(32'h0001_0000); fetch(32'h0001_0004);
      m_req_i = 1'b1; m_addr_i = 32'h0001_0008;
      @(negedge clk);
      chk("full_stall", m_gnt_o, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rst_async_gnt", m_gnt_o, 0);
      chk("rst_async_rvalid", m_rvalid_o, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; m_req_i = 1'b0;
      chk("post_rst_proto", proto_err_o, 0);
      fetch(32'h80);
      repeat (15) begin @(posedge clk); #1; end
      chk("late_rsp_proto", proto_err_o, 1);
      lat_fixed[1] = 0; gnt_always[1] = 1'b0;
      drain();

      random_phase(60);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/instr_bus_decoder.md
Name: instr_bus_decoder

Overview:
- Sits between the core instruction-fetch port and the instruction-side slaves: boot ROM and instruction SRAM.
- Decodes each fetch address and forwards the request to exactly one slave, or to an internal error responder for unmapped addresses.
- Tracks outstanding transactions in a small in-order FIFO and steers the matching response back to the core.
- All buses use the core req/gnt/rvalid protocol: address is accepted on req&gnt, and each grant produces one response on rvalid.

Parameters:
ROM_BASE, 32'h0000_0000, boot ROM base address
ROM_MASK, 32'hFFFF_FF00, ROM select mask (256 B window)
RAM_BASE, 32'h0001_0000, instruction SRAM base address
RAM_MASK, 32'hFFFF_0000, SRAM select mask (64 KiB window)
MAX_OUTSTANDING, 2, depth of the outstanding-target FIFO (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
m_req_i  in  1  core fetch request
m_gnt_o  out  1  grant to core
m_addr_i  in  32  core fetch address
m_rvalid_o  out  1  response valid to core
m_rdata_o  out  32  response data
m_rdata_intg_o  out  7  response integrity bits
m_err_o  out  1  response error
rom_req_o  out  1  ROM request
rom_gnt_i  in  1  ROM grant
rom_addr_o  out  32  ROM address
rom_rvalid_i  in  1  ROM response valid
rom_rdata_i  in  32  ROM data
rom_rdata_intg_i  in  7  ROM integrity bits
rom_err_i  in  1  ROM error
ram_req_o, ram_gnt_i, ram_addr_o, ram_rvalid_i, ram_rdata_i, ram_rdata_intg_i, ram_err_i: same widths and meanings as the ROM port, for instruction SRAM
proto_err_o  out  1  sticky flag: slave rvalid with no matching outstanding entry

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- While rst is high, all registers clear: FIFO empty, count=0, error-responder pending=0, proto_err_o=0. rom_req_o, ram_req_o, m_gnt_o and m_rvalid_o are forced 0.
- Decode (combinational):
  - tgt=ROM if (m_addr_i & ROM_MASK)==ROM_BASE.
  - Else tgt=RAM if (m_addr_i & RAM_MASK)==RAM_BASE.
  - Else tgt=ERR.
  - ROM takes priority if the windows overlap.
- Issue permission, allow:
  - count < MAX_OUTSTANDING, and
  - either count==0, or every outstanding entry has the same tgt as the new request.
  - This keeps responses in order with no reordering logic; switching targets waits for the FIFO to drain.
- Forwarding, same cycle (combinational):
  - rom_req_o = m_req_i & allow & tgt==ROM; ram_req_o likewise for RAM.
  - rom_addr_o and ram_addr_o = m_addr_i.
- Grant:
  - m_gnt_o = rom_req_o&rom_gnt_i | ram_req_o&ram_gnt_i | (m_req_i & allow & tgt==ERR).
  - On m_gnt_o, tgt is pushed into the FIFO.
- Error responder:
  - Each ERR grant increments pending.
  - An ERR response is emitted the cycle after the grant, so ERR latency is exactly 1 cycle.
  - An ERR response returns rdata=0, intg=0, err=1.
  - Back-to-back ERR grants produce back-to-back responses.
- Response path (combinational from slave inputs):
  - If FIFO non-empty and head==ROM: m_rvalid_o=rom_rvalid_i, and data, intg and err pass through from the ROM.
  - Same for RAM; for ERR, rvalid comes from the error responder.
  - When no response is valid, m_rdata_o, m_rdata_intg_o and m_err_o are 0.
  - On m_rvalid_o, the FIFO pops.
- Simultaneous push and pop in one cycle: count is unchanged and the FIFO pointers wrap modulo MAX_OUTSTANDING.
- A response may not arrive in the same cycle as its own grant; the slave contract requires latency >= 1.
- Protocol errors:
  - A rom_rvalid_i or ram_rvalid_i with FIFO empty, or with head != that slave, sets proto_err_o, which clears only on rst.
  - The stray response is not forwarded and the FIFO is unchanged.
- Stall: if m_req_i is high but allow=0, both slave req outputs stay low and m_gnt_o=0. The core holds its address.
- Reset mid-operation: all outstanding entries are discarded. A slave response arriving after reset deasserts is a protocol error per the rule above.

Decomposition:
- Package instr_bus_pkg holds:
  - typedef enum logic [1:0] tgt_e {TGT_ROM, TGT_RAM, TGT_ERR}
  - the ROM and RAM default base/mask localparams
  - the bus width constants (ADDR_W=32, DATA_W=32, INTG_W=7)
- One sub-module, instr_tgt_fifo: parameterised-depth tgt_e FIFO with push, pop, count, full, empty and head outputs, supporting simultaneous push/pop.
- Decode, issue control, error responder and response mux stay in the top module.

Test Plan:
- Single ROM fetch at 0x80, ROM responds 1 cycle after gnt with 0x00000513 -> m_gnt_o same cycle as req; m_rvalid_o next cycle with m_rdata_o=0x00000513, m_err_o=0.
- Four back-to-back ROM requests at 0x80..0x8C, ROM grants every cycle, 2-cycle response latency, MAX_OUTSTANDING=2 -> third request stalls (m_gnt_o=0) until first rvalid; data returns in order.
- Fetch at 0x4000_0000 (unmapped) -> rom_req_o=ram_req_o=0, m_gnt_o=1 same cycle; next cycle m_rvalid_o=1, m_err_o=1, m_rdata_o=0.
- ROM request at 0x80 outstanding, then RAM request at 0x0001_0000 -> ram_req_o held 0 until ROM rvalid pops; RAM granted the cycle after at the earliest, RAM data then returned.
- rom_rvalid_i pulsed with nothing outstanding -> proto_err_o=1 and stays 1; m_rvalid_o=0; a later normal ROM fetch still completes correctly.
- rst asserted with 2 RAM requests outstanding -> m_gnt_o and m_rvalid_o drop immediately; after release count=0; a late ram_rvalid_i sets proto_err_o.
